uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter BIT_MAX, default 8, data bits per byte.
REQ-003 Parameter TIMEOUT, default 62496, cycles allowed in WAIT or HOLD before abort (12 bit-times at BPS_MAX 5208).
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  N_REQ  per-requester byte-valid.
REQ-007 req_data  input  N_REQ*BIT_MAX  per-requester byte; requester i occupies bits [i*BIT_MAX +: BIT_MAX].
REQ-008 req_last  input  N_REQ  per-requester flag: the offered byte ends its packet.
REQ-009 req_ready  output  N_REQ  per-requester accept; a byte transfers on a posedge where req_valid[i] and req_ready[i] are both high.
REQ-010 tx_start  output  1  one-cycle pulse that starts the transmitter.
REQ-011 tx_data  output  BIT_MAX  byte presented to the transmitter; held stable from tx_start until tx_done.
REQ-012 tx_done  input  1  one-cycle pulse from the transmitter when the stop bit completes.
REQ-013 grant  output  N_REQ  one-hot owner of the transmitter; all-zero when no owner.
REQ-014 busy  output  1  high whenever the state is not IDLE.
REQ-015 timeout_err  output  1  one-cycle pulse on watchdog abort.

Function
REQ-016 The block SHALL implement states IDLE, START, WAIT and HOLD.
REQ-017 In IDLE, req_ready SHALL be one-hot on the arbitration winner and zero if no req_valid is high; it is combinational from req_valid and the pointer.
REQ-018 Round-robin: the winner SHALL be the first i with req_valid[i] high, scanning upward from ptr modulo N_REQ.
REQ-019 On an accept edge, the block SHALL load tx_data from the accepted slice, register last_r from req_last[i], set grant to one-hot i, and go to START.
REQ-020 START SHALL last exactly one cycle with tx_start high, then go to WAIT and clear the timer; accept-to-tx_start latency is 1 cycle.
REQ-021 In WAIT, tx_done SHALL go to IDLE when last_r is 1, or to HOLD when last_r is 0.
REQ-022 In HOLD, only the granted requester SHALL see req_ready high, and only while its req_valid is high; an accept loads as in REQ-019 and goes to START, so packets are never interleaved.
REQ-023 On release to IDLE after owner i, grant SHALL clear and ptr SHALL become (i+1) mod N_REQ.
REQ-024 The timer SHALL count every cycle in WAIT and HOLD; on reaching TIMEOUT-1 the block SHALL pulse timeout_err for one cycle, go to IDLE, clear grant and advance ptr as in REQ-023.
REQ-025 If tx_done and timer expiry fall on the same edge, tx_done SHALL take priority and timeout_err SHALL stay low.
REQ-026 tx_done in IDLE, START or HOLD SHALL be ignored.
REQ-027 req_ready SHALL be all-zero in START and WAIT.
REQ-028 A change of req_valid while not ready SHALL have no effect; no byte is dropped or duplicated.

Reset
REQ-029 When rst is high at a posedge, the block SHALL take these values: state IDLE, ptr 0, grant 0, tx_start 0, tx_data 0, last_r 0, timer 0, timeout_err 0, busy 0.
REQ-030 rst asserted mid-transfer SHALL abort the transfer without a tx_start or timeout_err pulse; the transmitter is reset by the same rst.

Configuration
REQ-031 Macro UART_ARB_FIXED_PRIO_EN: when defined, the winner SHALL be the lowest-index valid requester and ptr is unused; when undefined, round-robin per REQ-018/REQ-023 applies.

Verification
REQ-032 Reset: rst high for 2 cycles with all req_valid high -> req_ready, grant, tx_start and busy all 0; first accept goes to requester 0.
REQ-033 Single byte: req_valid[2]=1, req_data slice 0x5A, last=1 -> tx_start pulse 1 cycle after accept, tx_data=0x5A; after tx_done, grant=0 one cycle later and ptr=3.
REQ-034 Round-robin: all four valid with last=1 and ptr=0 -> service order 0,1,2,3,0; with UART_ARB_FIXED_PRIO_EN defined -> order 0,0,0 while req0 stays valid.
REQ-035 Packet lock: req1 sends 0x11,0x22,0x33 (last on 0x33) while req0 stays valid -> req0 gets no req_ready until after the tx_done for 0x33.
REQ-036 Timeout: TIMEOUT=16 and tx_done never arrives -> timeout_err pulses exactly 16 cycles after WAIT entry, then state is IDLE and grant is 0.
REQ-037 Collision: tx_done on the same edge as timer expiry -> no timeout_err; a mid-WAIT rst -> IDLE on the next edge and no further tx_start pulse.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between N_REQ byte sources. A requester that
//   wins arbitration keeps the transmitter until it sends a byte flagged as
//   the end of its packet, so packets are never interleaved. A watchdog
//   aborts an ownership that stalls in WAIT or HOLD for TIMEOUT cycles.
//
//   Build option: define UART_ARB_FIXED_PRIO_EN for fixed lowest-index
//   priority; otherwise arbitration is round-robin starting from ptr.
//
// Ports
//   clk          single clock, posedge
//   rst          synchronous active-high reset
//   req_valid    per-requester byte valid            [N_REQ]
//   req_data     per-requester byte, slice i*BIT_MAX [N_REQ*BIT_MAX]
//   req_last     per-requester end-of-packet flag    [N_REQ]
//   req_ready    per-requester accept                [N_REQ]
//   tx_start     one-cycle transmitter start pulse
//   tx_data      byte for the transmitter, stable until tx_done
//   tx_done      one-cycle transmitter completion pulse
//   grant        one-hot current owner, zero when free
//   busy         state is not IDLE
//   timeout_err  one-cycle pulse on watchdog abort
//
// state | meaning
// IDLE  | no owner, arbitrating among valid requesters
// START | byte latched, tx_start high for one cycle
// WAIT  | byte on the wire, waiting for tx_done
// HOLD  | packet still open, only the owner may offer its next byte

module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int BIT_MAX = 8,
    parameter int TIMEOUT = 62496
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*BIT_MAX-1:0] req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     tx_start,
    output logic [BIT_MAX-1:0]       tx_data,
    input  logic                     tx_done,
    output logic [N_REQ-1:0]         grant,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        ptr_q;
    logic [PW-1:0]        scan_base;
    logic [PW-1:0]        win_idx;
    logic [PW-1:0]        own_idx;
    logic [PW-1:0]        acc_idx;
    logic                 win_found;
    logic                 accept;
    logic                 release_own;
    logic                 timeout_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [N_REQ-1:0]     grant_q;
    logic [BIT_MAX-1:0]   tx_data_q;
    logic                 last_q;
    logic                 timeout_err_q;

`ifdef UART_ARB_FIXED_PRIO_EN
    assign scan_base = '0;
`else
    assign scan_base = ptr_q;
`endif

    // First valid requester scanning upward from scan_base, wrapping at N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int j;
            j = (int'(scan_base) + k) % N_REQ;
            if (!win_found && req_valid[j]) begin
                win_found = 1'b1;
                win_idx   = PW'(j);
            end
        end
    end

    always_comb begin
        own_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) own_idx = PW'(i);
        end
    end

    // Ready is forced low during reset so nothing transfers on a reset edge.
    always_comb begin
        req_ready = '0;
        acc_idx   = win_idx;
        if (!rst) begin
            unique case (state_q)
                IDLE: if (win_found) req_ready = N_REQ'(1) << win_idx;
                HOLD: req_ready = grant_q & req_valid;
                default: req_ready = '0;
            endcase
        end
        if (state_q == HOLD) acc_idx = own_idx;
    end

    assign accept = |(req_valid & req_ready);

    // tx_done is checked before the watchdog so a completion on the expiry
    // edge is never reported as a timeout.
    always_comb begin
        state_d     = state_q;
        release_own = 1'b0;
        timeout_d   = 1'b0;
        unique case (state_q)
            IDLE:  if (accept) state_d = START;
            START: state_d = WAIT;
            WAIT: begin
                if (tx_done) begin
                    if (last_q) begin
                        state_d     = IDLE;
                        release_own = 1'b1;
                    end else begin
                        state_d = HOLD;
                    end
                end else if (timer_q == T_LAST) begin
                    state_d     = IDLE;
                    release_own = 1'b1;
                    timeout_d   = 1'b1;
                end
            end
            HOLD: begin
                if (accept) begin
                    state_d = START;
                end else if (timer_q == T_LAST) begin
                    state_d     = IDLE;
                    release_own = 1'b1;
                    timeout_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Timer restarts on every entry to WAIT or HOLD and counts while the
    // state stays put.
    assign timer_d = ((state_d == WAIT || state_d == HOLD) && state_d == state_q)
                     ? timer_q + TW'(1) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            grant_q       <= '0;
            tx_data_q     <= '0;
            last_q        <= 1'b0;
            timer_q       <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            timeout_err_q <= timeout_d;
            if (accept) begin
                tx_data_q <= req_data[int'(acc_idx)*BIT_MAX +: BIT_MAX];
                last_q    <= req_last[acc_idx];
                grant_q   <= req_ready;
            end
            if (release_own) begin
                grant_q <= '0;
                ptr_q   <= PW'((int'(own_idx) + 1) % N_REQ);
            end
        end
    end

    assign tx_start    = (state_q == START);
    assign tx_data     = tx_data_q;
    assign grant       = grant_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed stimulus, a transaction-level
// reference (owner / pending start / waiting / age counters) compared against
// the DUT on every falling edge, plus literal expectations per scenario.

module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int BW = 8;
    localparam int T  = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '1;
    logic [N*BW-1:0] req_data = '0;
    logic [N-1:0]   req_last = '1;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [BW-1:0]  tx_data;
    logic           tx_done = 1'b0;
    logic [N-1:0]   grant;
    logic           busy;
    logic           timeout_err;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    bit lock_phase = 1'b0;
    bit r0_seen = 1'b0;

    uart_tx_arbiter #(.N_REQ(N), .BIT_MAX(BW), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
        .tx_done(tx_done), .grant(grant), .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    int         m_owner = -1;
    int         m_ptr = 0;
    int         m_age = 0;
    bit         m_start = 0;
    bit         m_wait = 0;
    bit         m_last = 0;
    bit         m_err = 0;
    logic [7:0] m_byte = '0;

    function automatic int pick(input logic [N-1:0] v, input int base);
        int b;
`ifdef UART_ARB_FIXED_PRIO_EN
        b = 0;
`else
        b = base;
`endif
        for (int k = 0; k < N; k++) begin
            if (v[(b + k) % N]) return (b + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int w;
        if (rst) return '0;
        if (m_owner < 0) begin
            w = pick(req_valid, m_ptr);
            return (w < 0) ? '0 : N'(1) << w;
        end
        if (!m_start && !m_wait) return req_valid & (N'(1) << m_owner);
        return '0;
    endfunction

    task automatic m_accept(input int i);
        m_owner = i;
        m_byte  = req_data[i*BW +: BW];
        m_last  = req_last[i];
        m_start = 1'b1;
    endtask

    task automatic m_release();
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_wait  = 1'b0;
    endtask

    always @(posedge clk) begin : model
        int w;
        m_err = 1'b0;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_age = 0; m_start = 0;
            m_wait = 0; m_last = 0; m_byte = '0;
        end else if (m_start) begin
            m_start = 1'b0;
            m_wait  = 1'b1;
            m_age   = 0;
        end else if (m_wait) begin
            if (tx_done) begin
                if (m_last) m_release();
                else begin
                    m_wait = 1'b0;
                    m_age  = 0;
                end
            end else if (m_age == T - 1) begin
                m_err = 1'b1;
                m_release();
            end else begin
                m_age++;
            end
        end else if (m_owner >= 0) begin
            if (req_valid[m_owner]) m_accept(m_owner);
            else if (m_age == T - 1) begin
                m_err = 1'b1;
                m_release();
            end else begin
                m_age++;
            end
        end else begin
            w = pick(req_valid, m_ptr);
            if (w >= 0) m_accept(w);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_ready", 32'(req_ready), 32'(exp_ready()));
            chk("m_grant", 32'(grant), (m_owner < 0) ? 32'd0 : 32'd1 << m_owner);
            chk("m_tx_start", 32'(tx_start), 32'(m_start));
            chk("m_tx_data", 32'(tx_data), 32'(m_byte));
            chk("m_busy", 32'(busy), 32'(m_owner >= 0));
            chk("m_timeout_err", 32'(timeout_err), 32'(m_err));
        end
        if (lock_phase && req_ready[0]) r0_seen = 1'b1;
    end

    // ---------------- stimulus helpers ----------------
    function automatic int onehot_idx(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (tx_start === 1'b1) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
        chk("wait_start_timeout", 32'd0, 32'd1);
    endtask

    task automatic done_pulse();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit ok;
        int got;
        int cnt;
        int exp_order[5];
        logic [7:0] pkt[3];
`ifdef UART_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        pkt = '{8'h11, 8'h22, 8'h33};

        for (int i = 0; i < N; i++) req_data[i*BW +: BW] = 8'hA0 + 8'(i);
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        chk("first_ready", 32'(req_ready), 32'b0001);

        // round-robin service order, all requesters valid, single-byte packets
        for (int k = 0; k < 5; k++) begin
            wait_start(ok);
            got = onehot_idx(grant);
            chk("rr_order", 32'(got), 32'(exp_order[k]));
            chk("rr_data", 32'(tx_data), 32'(8'hA0 + 8'(exp_order[k])));
            tick();
            tick();
            done_pulse();
        end
        req_valid = '0;
        tick();

        // single byte from requester 2
        req_data[2*BW +: BW] = 8'h5A;
        req_valid = 4'b0100;
        #1;
        chk("sb_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        chk("sb_tx_start", 32'(tx_start), 32'd1);
        chk("sb_tx_data", 32'(tx_data), 32'h5A);
        chk("sb_grant", 32'(grant), 32'b0100);
        tick();
        chk("sb_start_once", 32'(tx_start), 32'd0);
        done_pulse();
        chk("sb_grant_clr", 32'(grant), 32'd0);
        chk("sb_busy_clr", 32'(busy), 32'd0);
        req_valid = '1;
        #1;
`ifdef UART_ARB_FIXED_PRIO_EN
        chk("sb_ptr", 32'(req_ready), 32'b0001);
`else
        chk("sb_ptr", 32'(req_ready), 32'b1000);
`endif
        req_valid = '0;
        tick();

        // packet lock: requester 1 sends three bytes while requester 0 waits
        req_data[0 +: BW]  = 8'h0F;
        req_data[BW +: BW] = pkt[0];
        req_last  = 4'b0001;
        req_valid = 4'b0010;
        tick();
        req_valid  = 4'b0011;
        lock_phase = 1'b1;
        for (int b = 0; b < 3; b++) begin
            wait_start(ok);
            chk("lock_data", 32'(tx_data), 32'(pkt[b]));
            chk("lock_grant", 32'(grant), 32'b0010);
            tick();
            if (b < 2) begin
                req_data[BW +: BW] = pkt[b+1];
                req_last[1] = (b + 1 == 2);
            end
            tick();
            done_pulse();
            #1;
            if (b < 2) chk("lock_hold_ready", 32'(req_ready), 32'b0010);
        end
        lock_phase = 1'b0;
        chk("lock_r0_blocked", 32'(r0_seen), 32'd0);
        chk("lock_r0_after", 32'(req_ready), 32'b0001);
        req_valid = '0;
        req_last  = '1;
        tick();

        // watchdog: tx_done never arrives
        req_data[0 +: BW] = 8'h77;
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        chk("to_tx_start", 32'(tx_start), 32'd1);
        tick();
        got = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (timeout_err === 1'b1) begin
                got = c;
                break;
            end
        end
        chk("to_cycles", 32'(got), 32'd16);
        chk("to_busy", 32'(busy), 32'd0);
        chk("to_grant", 32'(grant), 32'd0);
        tick();
        chk("to_pulse_width", 32'(timeout_err), 32'd0);

        // tx_done on the watchdog expiry edge
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        repeat (15) tick();
        done_pulse();
        chk("coll_no_err", 32'(timeout_err), 32'd0);
        chk("coll_idle", 32'(busy), 32'd0);
        tick();
        chk("coll_no_err_late", 32'(timeout_err), 32'd0);

        // reset in the middle of WAIT
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_tx_start", 32'(tx_start), 32'd0);
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (tx_start === 1'b1 || timeout_err === 1'b1) cnt++;
        end
        chk("mid_rst_quiet", 32'(cnt), 32'd0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
